step_gen: RTL and testbench

STEP_GEN -- requirements
Module: step_gen

---
 rtl/step_pkg.sv | 15 +
 rtl/step_timer.sv | 35 +++
 rtl/step_gen.sv | 146 ++++++++++++++
 tb/tb_step_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared definitions for the step/direction pulse generator: FSM encoding and
// default pulse timing.
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam int PULSE_W_DEF   = 4;
    localparam int DIR_SETUP_DEF = 2;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter used to time the SETUP, HIGH and LOW phases.
// The count is held at zero once it gets there; load has priority.
module step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/step_gen.sv
// Step/direction pulse generator: produces fixed-width step pulses at a
// programmable period with direction setup time and an up/down position count.
module step_gen
    import step_pkg::*;
#(
    parameter int WIDTH_TR  = 16,
    parameter int WIDTH_CNT = 32,
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drv_en_TR,
    input  logic                 dir_TR,
    input  logic                 counter_en_TR,
    input  logic [WIDTH_TR-1:0]  period_TR,
    input  logic                 cnt_clr,
    output logic                 step,
    output logic                 dir,
    output logic                 drv_en,
    output logic                 step_tick,
    output logic                 busy,
    output logic [WIDTH_CNT-1:0] pos
);

    localparam logic [WIDTH_TR-1:0] MIN_P    = WIDTH_TR'(2 * PULSE_W);
    localparam logic [WIDTH_TR-1:0] PW       = WIDTH_TR'(PULSE_W);
    localparam logic [WIDTH_TR-1:0] PW_M1    = WIDTH_TR'(PULSE_W - 1);
    localparam logic [WIDTH_TR-1:0] SETUP_M1 = WIDTH_TR'(DIR_SETUP - 1);

    state_t               state_q;
    logic                 step_q;
    logic                 dir_q;
    logic                 drv_en_q;
    logic                 tick_q;
    logic                 busy_q;
    logic [WIDTH_CNT-1:0] pos_q;
    logic [WIDTH_TR-1:0]  period_q;

    logic                 t_zero;
    logic                 tmr_load;
    logic [WIDTH_TR-1:0]  tmr_val;
    logic                 start_ok;
    logic                 need_setup;
    logic                 decide;
    logic                 enter_high;
    logic                 enter_setup;
    logic [WIDTH_TR-1:0]  eff_period;

    step_timer #(
        .WIDTH (WIDTH_TR)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (t_zero)
    );

    // Start decision is taken in IDLE and on the last LOW cycle; both paths
    // share it so back-to-back steps and cold starts behave identically.
    always_comb begin
        start_ok    = drv_en_TR && (period_TR != '0);
        need_setup  = (dir_TR != dir_q);
        eff_period  = (period_TR > MIN_P) ? period_TR : MIN_P;
        decide      = (state_q == ST_IDLE) || ((state_q == ST_LOW) && t_zero);
        enter_setup = decide && start_ok && need_setup;
        enter_high  = (decide && start_ok && !need_setup) ||
                      ((state_q == ST_SETUP) && t_zero && drv_en_TR);
        tmr_load    = 1'b0;
        tmr_val     = '0;
        if (enter_setup) begin
            tmr_load = 1'b1;
            tmr_val  = SETUP_M1;
        end else if (enter_high) begin
            tmr_load = 1'b1;
            tmr_val  = PW_M1;
        end else if ((state_q == ST_HIGH) && t_zero) begin
            tmr_load = 1'b1;
            tmr_val  = period_q - PW - WIDTH_TR'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            drv_en_q <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            pos_q    <= '0;
            period_q <= '0;
        end else begin
            drv_en_q <= drv_en_TR;
            tick_q   <= 1'b0;
            if (enter_high) begin
                state_q  <= ST_HIGH;
                step_q   <= 1'b1;
                tick_q   <= 1'b1;
                busy_q   <= 1'b1;
                period_q <= eff_period;
            end else if (enter_setup) begin
                state_q <= ST_SETUP;
                dir_q   <= dir_TR;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_SETUP: begin
                        if (!drv_en_TR) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_HIGH: begin
                        if (t_zero) begin
                            state_q <= ST_LOW;
                            step_q  <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (t_zero) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // Clear wins over a count on the same edge.
            if (cnt_clr) begin
                pos_q <= '0;
            end else if (enter_high && counter_en_TR) begin
                pos_q <= dir_q ? pos_q + WIDTH_CNT'(1) : pos_q - WIDTH_CNT'(1);
            end
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign drv_en    = drv_en_q;
    assign step_tick = tick_q;
    assign busy      = busy_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_step_gen.sv
// Directed bench for step_gen: expected step events are queued as stimulus is
// applied and matched against edges captured by a negedge monitor.
module tb_step_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_en_TR = 1'b0;
    logic        dir_TR = 1'b0;
    logic        counter_en_TR = 1'b0;
    logic [15:0] period_TR = 16'd0;
    logic        cnt_clr = 1'b0;
    logic        step;
    logic        dir;
    logic        drv_en;
    logic        step_tick;
    logic        busy;
    logic [31:0] pos;

    step_gen #(
        .WIDTH_TR  (16),
        .WIDTH_CNT (32),
        .PULSE_W   (4),
        .DIR_SETUP (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .drv_en_TR     (drv_en_TR),
        .dir_TR        (dir_TR),
        .counter_en_TR (counter_en_TR),
        .period_TR     (period_TR),
        .cnt_clr       (cnt_clr),
        .step          (step),
        .dir           (dir),
        .drv_en        (drv_en),
        .step_tick     (step_tick),
        .busy          (busy),
        .pos           (pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          obs_n = 0;
    int          obs_cyc [256];
    logic [31:0] obs_pos [256];
    int          wid_n = 0;
    int          wid_v [256];
    int          hi_cnt = 0;

    always @(negedge clk) begin
        if (step_tick === 1'b1 && obs_n < 256) begin
            obs_cyc[obs_n] <= cyc;
            obs_pos[obs_n] <= pos;
            obs_n          <= obs_n + 1;
        end
        if (step === 1'b1) begin
            hi_cnt <= hi_cnt + 1;
        end else if (hi_cnt > 0) begin
            if (wid_n < 256) begin
                wid_v[wid_n] <= hi_cnt;
                wid_n        <= wid_n + 1;
            end
            hi_cnt <= 0;
        end
    end

    typedef struct {
        int          gap;
        logic [31:0] pos;
    } exp_t;

    exp_t exp_q [$];
    int   rd = 0;
    int   wid_rd = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int gap, input logic [31:0] p);
        exp_t e;
        e.gap = gap;
        e.pos = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (obs_n < rd + n && k < 200) begin
            wait_cycles(1);
            k++;
        end
        check("tick_wait", 64'(obs_n >= rd + n), 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            wait_cycles(1);
            k++;
        end
        check("idle_wait", 64'(busy), 64'd0);
        wait_cycles(3);
    endtask

    task automatic drain();
        exp_t e;
        check("tick_count", 64'(obs_n - rd), 64'(exp_q.size()));
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            if (e.gap > 0) begin
                check($sformatf("tick_gap[%0d]", rd), 64'(obs_cyc[rd] - obs_cyc[rd-1]), 64'(e.gap));
            end
            check($sformatf("tick_pos[%0d]", rd), 64'(obs_pos[rd]), 64'(e.pos));
            rd++;
        end
        exp_q.delete();
        rd = obs_n;
        while (wid_rd < wid_n) begin
            check($sformatf("pulse_width[%0d]", wid_rd), 64'(wid_v[wid_rd]), 64'd4);
            wid_rd++;
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        wait_cycles(2);
        check("rst_step", 64'(step), 64'd0);
        check("rst_dir", 64'(dir), 64'd0);
        check("rst_drv_en", 64'(drv_en), 64'd0);
        check("rst_tick", 64'(step_tick), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pos", 64'(pos), 64'd0);
        @(negedge clk) rst = 1'b1;
        wait_cycles(2);

        // Single step, unchanged dir: one-cycle latency, early drop of enable.
        period_TR = 16'd10; counter_en_TR = 1'b1; dir_TR = 1'b0; drv_en_TR = 1'b1;
        push(0, 32'hFFFF_FFFF);
        wait_cycles(1);
        check("latency_step", 64'(step), 64'd1);
        check("latency_tick", 64'(step_tick), 64'd1);
        check("drv_en_delay", 64'(drv_en), 64'd1);
        wait_cycles(1);
        drv_en_TR = 1'b0;
        check("tick_one_cycle", 64'(step_tick), 64'd0);
        check("high_2nd_cycle", 64'(step), 64'd1);
        wait_cycles(8);
        check("busy_last_low", 64'(busy), 64'd1);
        wait_cycles(1);
        check("busy_after_low", 64'(busy), 64'd0);
        wait_idle();
        drain();

        // Forward run with direction setup; first step wraps pos up to zero.
        dir_TR = 1'b1; drv_en_TR = 1'b1;
        push(0, 32'd0); push(10, 32'd1); push(10, 32'd2); push(10, 32'd3); push(10, 32'd4);
        wait_cycles(1);
        check("setup_no_step", 64'(step), 64'd0);
        check("setup_dir", 64'(dir), 64'd1);
        check("setup_busy", 64'(busy), 64'd1);
        wait_ticks(5);
        drv_en_TR = 1'b0;
        wait_idle();
        drain();
        check("pos_after_run", 64'(pos), 64'd4);

        // Clear, three forward steps, then reverse mid-run.
        cnt_clr = 1'b1;
        wait_cycles(1);
        cnt_clr = 1'b0;
        check("cnt_clr", 64'(pos), 64'd0);
        drv_en_TR = 1'b1;
        push(0, 32'd1); push(10, 32'd2); push(10, 32'd3); push(12, 32'd2);
        wait_ticks(3);
        dir_TR = 1'b0;
        wait_cycles(1);
        check("dir_held_in_step", 64'(dir), 64'd1);
        wait_ticks(4);
        drv_en_TR = 1'b0;
        check("dir_reversed", 64'(dir), 64'd0);
        wait_idle();
        drain();

        // Short period clamps to twice the pulse width; counting disabled.
        period_TR = 16'd3; counter_en_TR = 1'b0; drv_en_TR = 1'b1;
        push(0, 32'd2); push(8, 32'd2); push(8, 32'd2);
        wait_ticks(3);
        drv_en_TR = 1'b0;
        wait_idle();
        drain();

        // Zero period never steps; zeroing while running finishes the period.
        period_TR = 16'd0; drv_en_TR = 1'b1;
        wait_cycles(10);
        check("p0_busy", 64'(busy), 64'd0);
        check("p0_step", 64'(step), 64'd0);
        drain();
        counter_en_TR = 1'b1;
        push(0, 32'd1);
        period_TR = 16'd10;
        wait_ticks(1);
        period_TR = 16'd0;
        wait_idle();
        drain();
        drv_en_TR = 1'b0;

        // Asynchronous reset in the middle of a pulse, then restart.
        period_TR = 16'd10; drv_en_TR = 1'b1;
        push(0, 32'd0);
        wait_ticks(1);
        #2 rst = 1'b0;
        #1;
        check("arst_step", 64'(step), 64'd0);
        check("arst_pos", 64'(pos), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_tick", 64'(step_tick), 64'd0);
        #3 rst = 1'b1;
        push(0, 32'hFFFF_FFFF);
        wait_cycles(1);
        check("post_rst_step", 64'(step), 64'd1);
        wid_rd = wid_n;
        wait_cycles(1);
        drv_en_TR = 1'b0;
        wait_idle();
        drain();

        // Clear on the same edge as a step overrides the decrement.
        drv_en_TR = 1'b1; cnt_clr = 1'b1;
        push(0, 32'd0);
        wait_cycles(1);
        cnt_clr = 1'b0;
        check("clr_with_step", 64'(pos), 64'd0);
        wait_cycles(1);
        drv_en_TR = 1'b0;
        wait_idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
